// File: rtl/regfile_mp.sv
// Multi-read-port register file: one write port, registered reads, hardwired-zero R0,
// and a clear sequencer that zeroes the array after reset or clear_req. REGFILE_BYPASS_EN adds write-first forwarding.

module regfile_mp_rport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clearing,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);
  logic hit;

`ifdef REGFILE_BYPASS_EN
  // wr_en is already qualified with READY and a nonzero address
  assign hit = wr_en && (wr_addr == addr);
`else
  logic unused_wr;
  assign hit       = 1'b0;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (en) begin
      if (clearing || addr == '0) data <= '0;
      else if (hit)               data <= wr_data;
      else                        data <= word;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int N_RD   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     regwrite,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_drop
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {CLEAR, READY} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state, nxt_state;
  logic [ADDR_W-1:0] cnt, nxt_cnt;
  logic              clearing;
  wr_req_t           wq;

  logic [DATA_W-1:0]                mem [NREGS];
  logic [N_RD-1:0][ADDR_W-1:0]      raddr;
  logic [N_RD-1:0][DATA_W-1:0]      rword;
  logic [N_RD-1:0][DATA_W-1:0]      rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      CLEAR: begin
        nxt_cnt = cnt + 1'b1;
        if (cnt == LAST) nxt_state = READY;
      end
      READY: begin
        if (clear_req) begin
          nxt_state = CLEAR;
          nxt_cnt   = '0;
        end
      end
      default: nxt_state = CLEAR;
    endcase
  end

  assign clearing = (state == CLEAR);
  assign ready    = (state == READY);

  assign wq.en   = regwrite && ready && (wr_addr != '0);
  assign wq.addr = wr_addr;
  assign wq.data = wr_data;

  // Storage deliberately has no reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (clearing)   mem[cnt]     <= '0;
    else if (wq.en) mem[wq.addr] <= wq.data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_drop <= 1'b0;
    else        wr_drop <= regwrite && clearing;
  end

  assign raddr   = rd_addr;
  assign rd_data = rdata;

  for (genvar p = 0; p < N_RD; p++) begin : g_rport
    assign rword[p] = mem[raddr[p]];

    regfile_mp_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport (
      .clk      (clk),
      .reset    (reset),
      .clearing (clearing),
      .en       (rd_en[p]),
      .addr     (raddr[p]),
      .word     (rword[p]),
      .wr_en    (wq.en),
      .wr_addr  (wq.addr),
      .wr_data  (wq.data),
      .data     (rdata[p])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expected read data is queued when a read is issued
// and compared once the registered output appears.

module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int N_RD   = 2;
  localparam int NREGS  = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   clear_req = 1'b0;
  logic                   ready;
  logic [N_RD-1:0]        rd_en = '0;
  logic [N_RD*ADDR_W-1:0] rd_addr = '0;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic                   regwrite = 1'b0;
  logic [ADDR_W-1:0]      wr_addr = '0;
  logic [DATA_W-1:0]      wr_data = '0;
  logic                   wr_drop;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .regwrite(regwrite), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] val;
    string             tag;
  } exp_t;

  exp_t              sb[$];
  exp_t              e;
  logic [DATA_W-1:0] model [NREGS];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    regwrite = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    regwrite = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  task automatic rd(input int p, input logic [ADDR_W-1:0] a, input string tag);
    rd_en[p] = 1'b1;
    rd_addr[p*ADDR_W +: ADDR_W] = a;
    sb.push_back('{p, model[a], tag});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(); cyc();
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_checks++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_checks++;
    if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop: got %b want 0", wr_drop); end
    reset = 1'b1;
    begin
      int n = 0;
      while (!ready && n < 40) begin cyc(); n++; end
      n_checks++;
      if (n !== 16) begin n_fail++; $display("FAIL init_clear_len: got %0d cycles want 16", n); end
    end
    for (int a = 1; a < NREGS; a += 2) begin
      rd(0, ADDR_W'(a), "init_zero");
      if (a + 1 < NREGS) rd(1, ADDR_W'(a + 1), "init_zero");
      cyc(); rd_en = '0;
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_checks++;
        if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
          n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
        end
      end
    end
  endtask

  task automatic test_rw();
    wr(4'd2, 32'hAAAABBBB);
    wr(4'd3, 32'hCCCCDDDD);
    rd(0, 4'd2, "rw_r2"); rd(1, 4'd3, "rw_r3");
    cyc(); rd_en = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
        n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
      end
    end
    rd_addr = {4'd7, 4'd9};
    sb.push_back('{0, 32'hAAAABBBB, "hold_p0"});
    sb.push_back('{1, 32'hCCCCDDDD, "hold_p1"});
    cyc(); cyc();
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
        n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
      end
    end
  endtask

  task automatic test_r0();
    wr(4'd0, 32'hDEADBEEF);
    rd(0, 4'd0, "r0_p0"); rd(1, 4'd0, "r0_p1");
    cyc(); rd_en = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
        n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
      end
    end
  endtask

  task automatic test_collision();
    wr(4'd4, 32'h12345678);
    regwrite = 1'b1; wr_addr = 4'd4; wr_data = 32'h98765432;
    rd_en = 2'b11; rd_addr = {4'd2, 4'd4};
`ifdef REGFILE_BYPASS_EN
    sb.push_back('{0, 32'h98765432, "coll_new"});
`else
    sb.push_back('{0, 32'h12345678, "coll_old"});
`endif
    sb.push_back('{1, 32'hAAAABBBB, "coll_other_port"});
    cyc(); rd_en = '0; regwrite = 1'b0;
    model[4] = 32'h98765432;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
        n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
      end
    end
    rd(0, 4'd4, "coll_after"); rd(1, 4'd4, "coll_after");
    cyc(); rd_en = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
        n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a < NREGS; a++) wr(ADDR_W'(a), $urandom());
    for (int a = 1; a < NREGS; a++) begin
      rd(0, ADDR_W'(a), "b2b_p0"); rd(1, ADDR_W'(NREGS - a), "b2b_p1");
      cyc(); rd_en = '0;
      while (sb.size() > 0) begin
        e = sb.pop_front(); n_checks++;
        if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
          n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
        end
      end
    end
  endtask

  task automatic test_clear();
    int n = 0;
    wr(4'd5, 32'h11111111);
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    for (int a = 0; a < NREGS; a++) model[a] = '0;
    while (!ready && n < 40) begin
      if (n == 3) begin regwrite = 1'b1; wr_addr = 4'd6; wr_data = 32'h77777777; end
      if (n == 6) rd(0, 4'd2, "read_in_clear");
      cyc(); n++;
      if (n == 4) begin
        regwrite = 1'b0; n_checks++;
        if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL wr_drop_pulse: got %b want 1", wr_drop); end
      end
      if (n == 5) begin
        n_checks++;
        if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL wr_drop_end: got %b want 0", wr_drop); end
      end
      if (n == 7) begin
        rd_en = '0;
        while (sb.size() > 0) begin
          e = sb.pop_front(); n_checks++;
          if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
            n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
          end
        end
      end
    end
    n_checks++;
    if (n !== 16) begin n_fail++; $display("FAIL soft_clear_len: got %0d cycles want 16", n); end
    rd(0, 4'd5, "clr_r5"); rd(1, 4'd6, "clr_r6");
    cyc(); rd_en = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
        n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    wr(4'd9, 32'h5A5A5A5A);
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    reset = 1'b0;
    cyc(); cyc();
    n_checks++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL mid_reset_rd_data: got %h want 0", rd_data); end
    reset = 1'b1;
    for (int a = 0; a < NREGS; a++) model[a] = '0;
    while (!ready && n < 40) begin cyc(); n++; end
    n_checks++;
    if (n !== 16) begin n_fail++; $display("FAIL restart_clear_len: got %0d cycles want 16", n); end
    rd(0, 4'd9, "restart_r9"); rd(1, 4'd15, "restart_r15");
    cyc(); rd_en = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DATA_W +: DATA_W] !== e.val) begin
        n_fail++; $display("FAIL %s p%0d: got %h want %h", e.tag, e.port, rd_data[e.port*DATA_W +: DATA_W], e.val);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < NREGS; a++) model[a] = '0;
    test_reset();
    test_rw();
    test_r0();
    test_collision();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
